// File: rtl/arb42_pkg.sv
// Shared constants, state encodings and helpers for the arb42 round-robin arbiter.
package arb42_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  // Index of the set bit of a one-hot (or all-zero) grant; zero maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/arb42_rr_pick.sv
// Rotate-priority picker: first set request searching ptr, ptr+1, ... (mod 4).
module arb42_rr_pick
  import arb42_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic               any
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/arb42_rr.sv
// Four-requester round-robin arbiter with hold-until-release grants.
// Optional forced revocation after MAX_HOLD cycles when ARB42_TIMEOUT_EN is defined.
module arb42_rr
  import arb42_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb42_rr: MAX_HOLD must be in 2..255");
  end

  logic [0:0]         state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_any;

  arb42_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

`ifdef ARB42_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             timeout_nxt;
`endif

  // Next-state, grant and pointer update.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
`ifdef ARB42_TIMEOUT_EN
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_any) begin
          grant_nxt = pick_onehot;
          ptr_nxt   = onehot_to_idx(pick_onehot) + IDX_W'(1);
          state_nxt = OWN;
`ifdef ARB42_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      OWN: begin
`ifdef ARB42_TIMEOUT_EN
        if (hold_cnt != {CNT_W{1'b1}}) begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
`endif
        if ((req & grant) == '0) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
`ifdef ARB42_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          grant_nxt   = '0;
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
`endif
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; index and valid track the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      grant_idx   <= onehot_to_idx(grant_nxt);
      grant_valid <= |grant_nxt;
    end
  end

`ifdef ARB42_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
